// File: rtl/multiplier_pkg.sv
// Shared definitions for the add/shift multiplier controller.
// Contents:
//   MULT_WIDTH   - default operand width in bits
//   ctrl_state_t - controller states
//   cnt_width()  - width of the iteration counter for a given operand width
package multiplier_pkg;

   localparam int MULT_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ADD,
      SHIFT,
      HOLD
   } ctrl_state_t;

   // A one-bit operand still needs a one-bit counter.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/multiplier_control_if.sv
// Control bus between the multiplier controller and its datapath/user side.
// Parameter:
//   WIDTH        - operand width; sizes the debug counter view
// Signals:
//   Run, ClearA_LoadB - synchronized active-high user requests
//   M            - current LSB of register B
//   Clr_XA, Ld_B, Add, Sub, Shift - one-cycle datapath commands
//   Busy, Done   - controller status
//   dbg_state, dbg_cnt - controller state and bit counter, for observation
//
// Handshake: a multiply starts when Run is seen high in IDLE (and Run has been
// low at least once since reset). Done rises when the result is in A:B and
// stays high for as long as Run stays high; dropping Run releases the result
// and returns the controller to IDLE, so each press yields exactly one multiply.
interface multiplier_control_if
   import multiplier_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
);
   localparam int CNT_W = cnt_width(WIDTH);

   logic             Run;
   logic             ClearA_LoadB;
   logic             M;
   logic             Clr_XA;
   logic             Ld_B;
   logic             Add;
   logic             Sub;
   logic             Shift;
   logic             Busy;
   logic             Done;
   ctrl_state_t      dbg_state;
   logic [CNT_W-1:0] dbg_cnt;

   modport master (
      output Run, ClearA_LoadB, M,
      input  Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done, dbg_state, dbg_cnt
   );

   modport slave (
      input  Run, ClearA_LoadB, M,
      output Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done, dbg_state, dbg_cnt
   );

endinterface

// File: rtl/bit_counter.sv
// Iteration counter with synchronous clear, count enable and terminal flag.
// Ports:
//   clk - clock
//   clr - synchronous clear (wins over en)
//   en  - increment by one
//   cnt - current count
//   tc  - high while cnt equals TC
module bit_counter #(
   parameter int           W  = 3,
   parameter logic [W-1:0] TC = '1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + W'(1);
      end
   end

   assign tc = (cnt == TC);

endmodule

// File: rtl/multiplier_control.sv
// Sequencer for a signed add/shift multiplier (X:A:B datapath).
// Parameter:
//   WIDTH - operand width; one ADD/SHIFT pair per operand bit
// Ports:
//   Clk   - clock, rising edge
//   Reset - synchronous, active-high
//   bus   - control bus (requests in, datapath commands and status out)
module multiplier_control
   import multiplier_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic                 Clk,
   input  logic                 Reset,
   multiplier_control_if.slave  bus
);

   localparam int CNT_W = cnt_width(WIDTH);

   ctrl_state_t      state;
   ctrl_state_t      next_state;
   logic [CNT_W-1:0] cnt;
   logic             cnt_tc;
   logic             run_armed;
   logic             clr_xa;
   logic             ld_b;
   logic             add;
   logic             sub;
   logic             shift;
   logic             busy;
   logic             done;

   // run_armed blocks a Run that was already high coming out of reset; it is
   // set once Run is seen low. HOLD can only be left with Run low, so it never
   // needs clearing outside reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         run_armed <= 1'b0;
      end else begin
         state <= next_state;
         if (!bus.Run) begin
            run_armed <= 1'b1;
         end
      end
   end

   // Cleared on entry to a multiply; advances on every SHIFT except the last,
   // so cnt reads WIDTH-1 during the final ADD/SHIFT pair.
   bit_counter #(
      .W  (CNT_W),
      .TC (CNT_W'(WIDTH - 1))
   ) u_bit_counter (
      .clk (Clk),
      .clr (Reset || (state == CLEAR)),
      .en  ((state == SHIFT) && !cnt_tc),
      .cnt (cnt),
      .tc  (cnt_tc)
   );

   // Outputs are held low while Reset is high, even in the cycle before the
   // state register has returned to IDLE.
   always_comb begin
      next_state = state;
      clr_xa     = 1'b0;
      ld_b       = 1'b0;
      add        = 1'b0;
      sub        = 1'b0;
      shift      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      if (!Reset) begin
         case (state)
            IDLE: begin
               // A load request takes priority over a start in the same cycle.
               if (bus.ClearA_LoadB) begin
                  clr_xa = 1'b1;
                  ld_b   = 1'b1;
               end else if (bus.Run && run_armed) begin
                  next_state = CLEAR;
               end
            end
            CLEAR: begin
               clr_xa     = 1'b1;
               busy       = 1'b1;
               next_state = ADD;
            end
            ADD: begin
               // The MSB of a two's-complement multiplier has negative weight.
               add        = bus.M && !cnt_tc;
               sub        = bus.M && cnt_tc;
               busy       = 1'b1;
               next_state = SHIFT;
            end
            SHIFT: begin
               shift      = 1'b1;
               busy       = 1'b1;
               next_state = cnt_tc ? HOLD : ADD;
            end
            HOLD: begin
               done = 1'b1;
               if (bus.ClearA_LoadB) begin
                  clr_xa = 1'b1;
                  ld_b   = 1'b1;
               end
               if (!bus.Run) begin
                  next_state = IDLE;
               end
            end
            default: begin
               next_state = IDLE;
            end
         endcase
      end
   end

   assign bus.Clr_XA    = clr_xa;
   assign bus.Ld_B      = ld_b;
   assign bus.Add       = add;
   assign bus.Sub       = sub;
   assign bus.Shift     = shift;
   assign bus.Busy      = busy;
   assign bus.Done      = done;
   assign bus.dbg_state = state;
   assign bus.dbg_cnt   = cnt;

endmodule

// File: tb/tb_multiplier_control.sv
// Bench for multiplier_control: drives requests, models the X:A:B datapath
// from the controller's commands, and checks command sequences and products.
module tb_multiplier_control;
   import multiplier_pkg::*;

   localparam int W = MULT_WIDTH;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   multiplier_control_if #(.WIDTH(W)) mif ();

   multiplier_control #(.WIDTH(W)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (mif)
   );

   // ---------------- datapath model ----------------
   logic [7:0] sw_s = 8'h00;
   logic [7:0] sw_b = 8'h00;
   logic [7:0] a_r  = 8'h00;
   logic [7:0] b_r  = 8'h00;
   logic       x_r  = 1'b0;

   always @(posedge clk) begin
      if (mif.Clr_XA) begin
         a_r <= 8'h00;
         x_r <= 1'b0;
      end
      if (mif.Ld_B) b_r <= sw_b;
      if (mif.Add) {x_r, a_r} <= {a_r[7], a_r} + {sw_s[7], sw_s};
      if (mif.Sub) {x_r, a_r} <= {a_r[7], a_r} - {sw_s[7], sw_s};
      if (mif.Shift) begin
         a_r <= {x_r, a_r[7:1]};
         b_r <= {a_r[0], b_r[7:1]};
      end
   end

   assign mif.M = b_r[0];

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
      end
   endtask

   // {Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done}
   function automatic logic [6:0] outs();
      return {mif.Clr_XA, mif.Ld_B, mif.Add, mif.Sub, mif.Shift, mif.Busy, mif.Done};
   endfunction

   function automatic logic [15:0] onehot_ok();
      return 16'($countones({mif.Clr_XA, mif.Add, mif.Sub, mif.Shift}) <= 1);
   endfunction

   // ---------------- driver tasks ----------------
   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic r, input logic run, input logic cl);
      @(negedge clk);
      rst              = r;
      mif.Run          = run;
      mif.ClearA_LoadB = cl;
      #1;
   endtask

   // One full multiply. Expected commands come from the bits of b:
   // step 0 clears, then for each bit i an ADD step (add if set, subtract for
   // the top bit) and a SHIFT step. abort_k >= 0 applies reset at that step.
   task automatic do_mult(input logic [7:0] s, input logic [7:0] b, input bit combined,
                          input int abort_k, input int hold_extra,
                          input logic [15:0] req_prod, input string tag);
      logic [6:0] e;
      int         i;
      logic       mb;
      logic       cl;
      sw_s = s;
      sw_b = b;
      drive(1'b0, combined, 1'b1);
      check({tag, ":load"}, 16'(outs()), 16'(7'b1100000));
      drive(1'b0, 1'b1, 1'b0);
      check({tag, ":idle"}, 16'(outs()), 16'h0000);
      for (int k = 0; k <= 2 * W; k++) begin
         cl = (k == 5);
         drive(1'b0, 1'b1, cl);
         if (k == abort_k) begin
            check({tag, ":abort_state"}, 16'(mif.dbg_state), 16'(SHIFT));
            check({tag, ":abort_cnt"}, 16'(mif.dbg_cnt), 16'((k - 2) / 2));
            rst = 1'b1;
            #1;
            check({tag, ":in_reset"}, 16'(outs()), 16'h0000);
            drive(1'b0, 1'b1, 1'b0);
            check({tag, ":post_state"}, 16'(mif.dbg_state), 16'(IDLE));
            check({tag, ":post_cnt"}, 16'(mif.dbg_cnt), 16'h0000);
            check({tag, ":post_outs"}, 16'(outs()), 16'h0000);
            for (int j = 0; j < 3; j++) begin
               drive(1'b0, 1'b1, 1'b0);
               check({tag, ":no_restart"}, 16'(outs()), 16'h0000);
            end
            drive(1'b0, 1'b0, 1'b0);
            return;
         end
         if (k == 0) begin
            e = 7'b1000010;
         end else if (k % 2 == 1) begin
            i  = (k - 1) / 2;
            mb = b[i];
            e  = {2'b00, mb && (i < W - 1), mb && (i == W - 1), 3'b010};
         end else begin
            e = 7'b0000110;
         end
         check($sformatf("%s:step%0d", tag, k), 16'(outs()), 16'(e));
         check($sformatf("%s:onehot%0d", tag, k), onehot_ok(), 16'h0001);
      end
      drive(1'b0, 1'b1, 1'b0);
      check({tag, ":hold"}, 16'(outs()), 16'(7'b0000001));
      check({tag, ":product"}, {a_r, b_r}, req_prod);
      for (int h = 0; h < hold_extra; h++) begin
         cl = (h == 1);
         drive(1'b0, 1'b1, cl);
         check($sformatf("%s:hold%0d", tag, h), 16'(outs()), cl ? 16'(7'b1100001) : 16'(7'b0000001));
      end
      drive(1'b0, 1'b0, 1'b0);
      check({tag, ":release"}, 16'(outs()), 16'(7'b0000001));
      drive(1'b0, 1'b0, 1'b0);
      check({tag, ":back_idle"}, 16'(mif.dbg_state), 16'(IDLE));
      check({tag, ":idle_outs"}, 16'(outs()), 16'h0000);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [7:0]  s;
      logic [7:0]  b;
      bit          combined;
      int          hold;
      logic [15:0] prod;
   } vec_t;

   vec_t vecs[9];

   function automatic logic [15:0] model_prod(input logic [7:0] s, input logic [7:0] b);
      int p;
      p = $signed(s) * $signed(b);
      return 16'(p);
   endfunction

   initial begin
      vecs[0] = '{8'h02, 8'hD6, 1'b0, 0, 16'hFFAC};
      vecs[1] = '{8'h00, 8'h5A, 1'b0, 1, 16'h0000};
      vecs[2] = '{8'h80, 8'h80, 1'b1, 2, 16'h4000};
      vecs[3] = '{8'h7F, 8'h7F, 1'b0, 0, 16'h3F01};
      vecs[4] = '{8'hFF, 8'h01, 1'b1, 0, 16'hFFFF};
      vecs[5] = '{8'h01, 8'h80, 1'b0, 3, 16'hFF80};
      vecs[6] = '{8'h80, 8'h7F, 1'b0, 1, 16'hC080};
      vecs[7] = '{8'h05, 8'h00, 1'b0, 0, 16'h0000};
      vecs[8] = '{8'hFF, 8'hFF, 1'b1, 2, 16'h0001};

      rst              = 1'b1;
      mif.Run          = 1'b1;
      mif.ClearA_LoadB = 1'b0;

      // Reset held two cycles with Run high; a load request is also ignored.
      drive(1'b1, 1'b1, 1'b0);
      check("rst_outs0", 16'(outs()), 16'h0000);
      drive(1'b1, 1'b1, 1'b1);
      check("rst_outs1", 16'(outs()), 16'h0000);
      drive(1'b0, 1'b1, 1'b0);
      check("rst_state", 16'(mif.dbg_state), 16'(IDLE));
      check("rst_cnt", 16'(mif.dbg_cnt), 16'h0000);
      for (int j = 0; j < 3; j++) begin
         drive(1'b0, 1'b1, 1'b0);
         check("rst_no_start", 16'(outs()), 16'h0000);
      end
      drive(1'b0, 1'b0, 1'b0);
      check("run_low", 16'(outs()), 16'h0000);
      drive(1'b0, 1'b1, 1'b0);
      check("run_high_idle", 16'(outs()), 16'h0000);
      drive(1'b0, 1'b1, 1'b0);
      check("fresh_start_clear", 16'(outs()), 16'(7'b1000010));
      drive(1'b1, 1'b0, 1'b0);
      check("abort_clear", 16'(outs()), 16'h0000);
      drive(1'b0, 1'b0, 1'b0);
      check("abort_clear_state", 16'(mif.dbg_state), 16'(IDLE));

      // Single-cycle load request in IDLE.
      sw_b = 8'h3C;
      drive(1'b0, 1'b0, 1'b1);
      check("load_pulse", 16'(outs()), 16'(7'b1100000));
      drive(1'b0, 1'b0, 1'b0);
      check("load_once", 16'(outs()), 16'h0000);
      check("load_b", 16'(b_r), 16'h003C);

      // Directed table.
      for (int v = 0; v < 9; v++) begin
         do_mult(vecs[v].s, vecs[v].b, vecs[v].combined, -1, vecs[v].hold, vecs[v].prod,
                 $sformatf("vec%0d", v));
      end

      // Run held high for 40 cycles in total.
      do_mult(8'h02, 8'hD6, 1'b0, -1, 21, 16'hFFAC, "run40");

      // Reset during SHIFT with cnt = 3.
      do_mult(8'h03, 8'hB5, 1'b0, 8, 0, 16'h0000, "abort");

      // Randomized operands against the arithmetic model.
      for (int r = 0; r < 25; r++) begin
         logic [7:0] rs;
         logic [7:0] rb;
         rs = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         do_mult(rs, rb, 1'($urandom_range(0, 1)), -1, $urandom_range(0, 3),
                 model_prod(rs, rb), $sformatf("rnd%0d", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
